charlieplex_scanner: RTL and testbench
======================================

# charlieplex_scanner

Time-multiplexed charlieplex display driver. Holds a per-LED brightness framebuffer and continuously scans all PINCOUNT*(PINCOUNT-1) LEDs, lighting one LED at a time with PWM dimming and blanking between slots to suppress ghosting. It sits between a framebuffer-writing host (CPU/bus or pattern generator) and the tristate I/O pads of the charlieplex matrix. It is the clocked, multi-LED successor of the single-index combinational charlieplexer.

## Interface
- PINCOUNT, 4, matrix pins (≥2); LEDCOUNT = PINCOUNT*(PINCOUNT-1), INDEXBITS = $clog2(LEDCOUNT)
- BRIGHTBITS, 4, brightness width (≥1); PWM phase length P = 2^BRIGHTBITS - 1 cycles
- BLANK, 2, blanking cycles per slot (≥1); slot length S = BLANK + P; frame = LEDCOUNT*S cycles

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  global output enable; low forces all out_en to 0, scanning continues
- wr_en  in  1  framebuffer write strobe
- wr_addr  in  INDEXBITS  LED index to write; values ≥ LEDCOUNT ignored
- wr_data  in  BRIGHTBITS  brightness level; 0 = off, 2^BRIGHTBITS-1 = on for whole PWM phase
- swap  in  1  buffer swap request (present only with CHARLIEPLEX_SCANNER_DOUBLEBUF_EN)
- out_en  out  PINCOUNT  per-pin drive enable (0 = tristate)
- out_value  out  PINCOUNT  per-pin drive level (1 = VCC, 0 = GND)
- frame_start  out  1  one-cycle pulse at the first cycle of each frame

## Operation
- LED index n ↔ (anode column x, cathode row y), x≠y: n = x*(PINCOUNT-1) + (y<x ? y : y-1). Lit LED: out_en[x]=out_en[y]=1, out_value[x]=1, all other out_en/out_value bits 0.
- Scan state: index (0..LEDCOUNT-1), phase {BLANK, PWM}, phase counter.
- BLANK: BLANK cycles, all out_en=0, out_value=0. Last BLANK cycle → PWM; level for current index latched from framebuffer on that transition.
- PWM: cycles k=0..P-1; LED lit in cycle k iff k < level and enable=1; otherwise all outputs 0. Last PWM cycle → BLANK of index+1; index LEDCOUNT-1 wraps to 0.
- Writes: registered on clk when wr_en=1 and wr_addr<LEDCOUNT. A write to the LED currently in PWM does not affect the current slot (level already latched); it applies from that LED's next slot. Write on the latch edge for the same LED: the latched level is the old value.
- enable: combined into the output registers; deassert/assert takes effect on the next cycle's outputs; counters unaffected.
- Reset: framebuffer(s) cleared to 0, index=0, phase=BLANK, counter=0, latched level=0, out_en=0, out_value=0, frame_start=0. Reset mid-slot aborts the slot immediately (outputs tristate asynchronously).

## Timing
- All outputs registered; they reflect the scan state of the current cycle, no additional latency.
- First cycle after reset release = BLANK cycle 0 of LED 0.
- frame_start registered high for exactly the cycle in BLANK cycle 0 of LED 0, on every frame entry by wrap from LED LEDCOUNT-1; the first frame after reset release is not flagged (first pulse at cycle LEDCOUNT*S after release).
- Write-to-visible latency: at most one frame + BLANK cycles.

## Configuration
- CHARLIEPLEX_SCANNER_DOUBLEBUF_EN defined: two framebuffers (front scanned, back written); swap port present. swap=1 for one cycle sets a sticky pending flag; the exchange happens on the edge entering BLANK cycle 0 of LED 0 (the frame_start cycle), then pending clears. swap asserted on that same edge is performed at that boundary. Multiple requests within one frame collapse to one swap. No content copy: post-swap back buffer holds the former front contents.
- Undefined: single framebuffer, writes scanned directly; swap port absent.

## Test plan
Parameters PINCOUNT=3, BRIGHTBITS=2, BLANK=1 (LEDCOUNT=6, P=3, S=4, frame 24 cycles) unless noted.
- Reset, no writes, enable=1 → out_en=0 forever; frame_start first high at cycle 24 after release, then every 24 cycles.
- Write LED0=3 → during its PWM cycles out_en=3'b011, out_value=3'b001 for 3 cycles; BLANK cycles all zero.
- Write LED3=1 → in slot 3 out_en=3'b110, out_value=3'b010 for PWM cycle 0 only, 0 for cycles 1-2.
- Write LED2=2 during LED2's PWM phase (old 0) → current slot dark, next frame lit 2 cycles; wr_addr=6 → no effect.
- enable dropped mid-PWM of lit LED → out_en=0 next cycle; re-raise → pattern resumes at correct k; frame_start period unchanged; rst pulse mid-slot → outputs 0 immediately, framebuffer reads 0.
- DOUBLEBUF_EN: write back LED0=3, no swap → dark; pulse swap mid-frame → LED0 lit from next frame_start; two swaps in one frame → single exchange.

Source files
------------

// File: rtl/charlieplex_scanner.sv
// charlieplex_scanner: scans a charlieplex LED matrix one LED at a time, with PWM dimming and a blanking gap before each LED.
// Define CHARLIEPLEX_SCANNER_DOUBLEBUF_EN for two framebuffers (front scanned, back written) and a swap port.
module charlieplex_scanner #(
    parameter int PINCOUNT   = 4,
    parameter int BRIGHTBITS = 4,
    parameter int BLANK      = 2,
    localparam int LEDCOUNT  = PINCOUNT * (PINCOUNT - 1),
    localparam int INDEXBITS = $clog2(LEDCOUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [INDEXBITS-1:0]  wr_addr,
    input  logic [BRIGHTBITS-1:0] wr_data,
`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
    input  logic                  swap,
`endif
    output logic [PINCOUNT-1:0]   out_en,
    output logic [PINCOUNT-1:0]   out_value,
    output logic                  frame_start
);

    localparam int PWMLEN  = (1 << BRIGHTBITS) - 1;
    localparam int CNTMAX  = (BLANK > PWMLEN) ? BLANK : PWMLEN;
    localparam int CNTBITS = $clog2(CNTMAX + 1);

    typedef enum logic {PH_BLANK, PH_PWM} phase_t;

    phase_t                phase, phase_nxt;
    logic [CNTBITS-1:0]    cnt, cnt_nxt;
    logic [INDEXBITS-1:0]  index, index_nxt;
    logic [BRIGHTBITS-1:0] level, level_nxt, front_level;
    logic                  wrap;
    logic [PINCOUNT-1:0]   en_nxt, val_nxt;
    logic                  wr_ok;

    assign wr_ok = wr_en && (int'(wr_addr) < LEDCOUNT);

`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
    logic [BRIGHTBITS-1:0] fb [2][LEDCOUNT];
    logic                  front, swap_pending;
    assign front_level = fb[front][index];
`else
    logic [BRIGHTBITS-1:0] fb [LEDCOUNT];
    assign front_level = fb[index];
`endif

    // Outputs are registered from the next scan state so they describe the cycle the state registers enter.
    always_comb begin
        index_nxt = index;
        phase_nxt = phase;
        cnt_nxt   = cnt + 1'b1;
        level_nxt = level;
        wrap      = 1'b0;
        if (phase == PH_BLANK) begin
            if (cnt == CNTBITS'(BLANK - 1)) begin
                phase_nxt = PH_PWM;
                cnt_nxt   = '0;
                level_nxt = front_level;
            end
        end else if (cnt == CNTBITS'(PWMLEN - 1)) begin
            phase_nxt = PH_BLANK;
            cnt_nxt   = '0;
            if (index == INDEXBITS'(LEDCOUNT - 1)) begin
                index_nxt = '0;
                wrap      = 1'b1;
            end else begin
                index_nxt = index + 1'b1;
            end
        end
    end

    // Index n maps to anode x = n/(PINCOUNT-1); the cathode skips over the anode pin.
    always_comb begin
        int x, r, y;
        x = int'(index_nxt) / (PINCOUNT - 1);
        r = int'(index_nxt) % (PINCOUNT - 1);
        y = (r < x) ? r : r + 1;
        en_nxt  = '0;
        val_nxt = '0;
        if (phase_nxt == PH_PWM && enable && int'(cnt_nxt) < int'(level_nxt)) begin
            en_nxt  = (PINCOUNT'(1) << x) | (PINCOUNT'(1) << y);
            val_nxt = PINCOUNT'(1) << x;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= PH_BLANK;
            cnt         <= '0;
            index       <= '0;
            level       <= '0;
            out_en      <= '0;
            out_value   <= '0;
            frame_start <= 1'b0;
            // NOTE: the framebuffer must read as zero after reset, so it is built from resettable flops, not a RAM macro.
`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < LEDCOUNT; i++) fb[b][i] <= '0;
            front        <= 1'b0;
            swap_pending <= 1'b0;
`else
            for (int i = 0; i < LEDCOUNT; i++) fb[i] <= '0;
`endif
        end else begin
            phase       <= phase_nxt;
            cnt         <= cnt_nxt;
            index       <= index_nxt;
            level       <= level_nxt;
            out_en      <= en_nxt;
            out_value   <= val_nxt;
            frame_start <= wrap;
`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
            if (wr_ok) fb[~front][wr_addr] <= wr_data;
            // A request arriving on the boundary edge itself is honoured at that boundary.
            if (wrap) begin
                if (swap_pending || swap) front <= ~front;
                swap_pending <= 1'b0;
            end else if (swap) begin
                swap_pending <= 1'b1;
            end
`else
            if (wr_ok) fb[wr_addr] <= wr_data;
`endif
        end
    end

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Self-checking bench for charlieplex_scanner (PINCOUNT=3, BRIGHTBITS=2, BLANK=1: 6 LEDs, 4-cycle slots, 24-cycle frame).
module tb_charlieplex_scanner;
    localparam int LEDS  = 6;
    localparam int S     = 4;
    localparam int BLNK  = 1;
    localparam int FRAME = 24;
    localparam logic [2:0] PIN_EN  [LEDS] = '{3'b011, 3'b101, 3'b011, 3'b110, 3'b101, 3'b110};
    localparam logic [2:0] PIN_VAL [LEDS] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

    logic       clk = 1'b0, rst = 1'b0, enable = 1'b0, wr_en = 1'b0, swap = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic [2:0] out_en, out_value;
    logic       frame_start;

    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    charlieplex_scanner #(.PINCOUNT(3), .BRIGHTBITS(2), .BLANK(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
        .swap        (swap),
`endif
        .out_en      (out_en),
        .out_value   (out_value),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [2:0] en;
        logic [2:0] val;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: cycle count since reset release, framebuffer copy, latched level.
    int         t;
    logic [1:0] m_fb [2][LEDS];
    logic [1:0] m_level;
    logic       m_front, m_pending;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if ({out_en, out_value, frame_start} !== mon_e) begin
                miscompares++;
                $display("FAIL scan t=%0d: got en=%b val=%b fs=%b, want en=%b val=%b fs=%b",
                         t, out_en, out_value, frame_start, mon_e.en, mon_e.val, mon_e.fs);
            end
        end
    end

    task automatic model_reset();
        t = 0;
        m_level = '0;
        m_front = 1'b0;
        m_pending = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < LEDS; i++) m_fb[b][i] = '0;
    endtask

    // Drive one cycle of inputs, predict the outputs of the cycle the next edge enters, then let it happen.
    task automatic step(input logic we, input logic [2:0] a, input logic [1:0] d, input logic sw);
        int   slot, pos;
        logic wb;
        exp_t e;
        wr_en = we; wr_addr = a; wr_data = d; swap = sw;
`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
        wb = ~m_front;
`else
        wb = m_front;
`endif
        t++;
        slot = (t / S) % LEDS;
        pos  = t % S;
        if (pos == BLNK) m_level = m_fb[m_front][slot];
        if (pos == 0 && slot == 0) begin
            if (m_pending || sw) m_front = ~m_front;
            m_pending = 1'b0;
        end else if (sw) begin
            m_pending = 1'b1;
        end
        if (we && a < 3'(LEDS)) m_fb[wb][a] = d;
        e = '0;
        if (pos >= BLNK && (pos - BLNK) < int'(m_level) && enable) begin
            e.en  = PIN_EN[slot];
            e.val = PIN_VAL[slot];
        end
        e.fs = (pos == 0 && slot == 0);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        wr_en = 1'b0; swap = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 2'd0, 1'b0);
    endtask

    task automatic advance_to(input int ph);
        int n = 0;
        while ((t % FRAME) != ph && n < 2 * FRAME) begin
            step(1'b0, 3'd0, 2'd0, 1'b0);
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_en !== 3'b000 || out_value !== 3'b000 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got en=%b val=%b fs=%b, want all 0", out_en, out_value, frame_start);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (out_en !== 3'b000 || out_value !== 3'b000 || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got en=%b val=%b fs=%b, want all 0", out_en, out_value, frame_start);
        end
    endtask

    task automatic test_reset();
        enable = 1'b1;
        do_reset();
    endtask

    task automatic test_frame_start();
        int first = -1, pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 3'd0, 2'd0, 1'b0);
            if (frame_start === 1'b1) begin
                pulses++;
                if (first < 0) first = t;
            end
        end
        vectors++;
        if (first !== 24) begin
            miscompares++;
            $display("FAIL first_frame_start: got cycle %0d, want 24", first);
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL frame_start_count: got %0d, want 2", pulses);
        end
    endtask

    task automatic test_led0_full();
        step(1'b1, 3'd0, 2'd3, 1'b0);
        advance_to(0);
        vectors++;
        if (out_en !== 3'b000) begin
            miscompares++;
            $display("FAIL led0_blank: got en=%b, want 000", out_en);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd0, 2'd0, 1'b0);
            vectors++;
            if (out_en !== 3'b011 || out_value !== 3'b001) begin
                miscompares++;
                $display("FAIL led0_pwm k=%0d: got en=%b val=%b, want en=011 val=001", k, out_en, out_value);
            end
        end
    endtask

    task automatic test_led3_partial();
        logic [2:0] want_en [3] = '{3'b110, 3'b000, 3'b000};
        step(1'b1, 3'd3, 2'd1, 1'b0);
        advance_to(12);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd0, 2'd0, 1'b0);
            vectors++;
            if (out_en !== want_en[k] || out_value !== (k == 0 ? 3'b010 : 3'b000)) begin
                miscompares++;
                $display("FAIL led3_pwm k=%0d: got en=%b val=%b, want en=%b", k, out_en, out_value, want_en[k]);
            end
        end
    endtask

    task automatic test_write_during_pwm();
        advance_to(9);
        step(1'b1, 3'd2, 2'd2, 1'b0);
        step(1'b1, 3'd6, 2'd3, 1'b0);
        vectors++;
        if (out_en !== 3'b000) begin
            miscompares++;
            $display("FAIL led2_current_slot: got en=%b, want 000", out_en);
        end
        // Write LED1 on the edge that latches LED1's level: this slot keeps the old level.
        advance_to(4);
        step(1'b1, 3'd1, 2'd3, 1'b0);
        vectors++;
        if (out_en !== 3'b000) begin
            miscompares++;
            $display("FAIL led1_latch_edge: got en=%b, want 000", out_en);
        end
        advance_to(9);
        vectors++;
        if (out_en !== 3'b011 || out_value !== 3'b010) begin
            miscompares++;
            $display("FAIL led2_next_frame: got en=%b val=%b, want en=011 val=010", out_en, out_value);
        end
        idle(2);
        vectors++;
        if (out_en !== 3'b000) begin
            miscompares++;
            $display("FAIL led2_k2_dark: got en=%b, want 000", out_en);
        end
        advance_to(5);
        vectors++;
        if (out_en !== 3'b101 || out_value !== 3'b001) begin
            miscompares++;
            $display("FAIL led1_next_frame: got en=%b val=%b, want en=101 val=001", out_en, out_value);
        end
    endtask

    task automatic test_enable();
        advance_to(1);
        enable = 1'b0;
        step(1'b0, 3'd0, 2'd0, 1'b0);
        vectors++;
        if (out_en !== 3'b000) begin
            miscompares++;
            $display("FAIL enable_low: got en=%b, want 000", out_en);
        end
        enable = 1'b1;
        step(1'b0, 3'd0, 2'd0, 1'b0);
        vectors++;
        if (out_en !== 3'b011) begin
            miscompares++;
            $display("FAIL enable_resume: got en=%b, want 011", out_en);
        end
        advance_to(0);
        vectors++;
        if (frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL enable_frame_period: got fs=%b, want 1", frame_start);
        end
    endtask

    task automatic test_reset_mid_slot();
        int lit = 0;
        advance_to(2);
        rst = 1'b1;
        #1;
        vectors++;
        if (out_en !== 3'b000 || out_value !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: got en=%b val=%b, want 000 000", out_en, out_value);
        end
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 3'd0, 2'd0, 1'b0);
            if (out_en !== 3'b000) lit++;
        end
        vectors++;
        if (lit !== 0) begin
            miscompares++;
            $display("FAIL fb_cleared: got %0d lit cycles, want 0", lit);
        end
    endtask

`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
    task automatic test_doublebuf();
        step(1'b1, 3'd0, 2'd3, 1'b0);
        advance_to(1);
        vectors++;
        if (out_en !== 3'b000) begin
            miscompares++;
            $display("FAIL db_back_hidden: got en=%b, want 000", out_en);
        end
        advance_to(12);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        advance_to(1);
        vectors++;
        if (out_en !== 3'b011) begin
            miscompares++;
            $display("FAIL db_after_swap: got en=%b, want 011", out_en);
        end
        advance_to(5);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        advance_to(15);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        advance_to(1);
        vectors++;
        if (out_en !== 3'b000) begin
            miscompares++;
            $display("FAIL db_double_swap_collapse: got en=%b, want 000", out_en);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_frame_start();
`ifdef CHARLIEPLEX_SCANNER_DOUBLEBUF_EN
        test_doublebuf();
`else
        test_led0_full();
        test_led3_partial();
        test_write_during_pwm();
        test_enable();
        test_reset_mid_slot();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
